pio_rw_wmem_nw: RTL

- PIO-accessible wide memory generalised to any WIDTH, split into NWORDS = ceil(WIDTH/32) PIO words per entry.
- Provides an application read/write port with priority over PIO, plus a hardware clear engine that zero-fills the whole array.
- Sits between the PIO register decoder (slow clk_div-qualified ack domain) and datapath tables built on ram_1r1w_bram.

---
 rtl/pio_rw_wmem_nw_if.sv | 40 ++++
 rtl/pio_rw_wmem_nw.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pio_rw_wmem_nw_if.sv
// Bundles the PIO register bus, the application memory port and clear control of pio_rw_wmem_nw.
// Pure wiring, no latency.
// No backpressure: PIO is single-outstanding by decoder contract, app requests are always accepted.
interface pio_rw_wmem_nw_if #(
    parameter int WIDTH       = 72,
    parameter int DEPTH_NBITS = 10
);
    logic                   clk_div;
    logic [31:0]            reg_addr;
    logic [31:0]            reg_din;
    logic                   reg_rd;
    logic                   reg_wr;
    logic                   reg_ms;
    logic                   mem_ack;
    logic [31:0]            mem_rdata;
    logic                   app_mem_rd;
    logic [DEPTH_NBITS-1:0] app_mem_raddr;
    logic                   app_mem_wr;
    logic [DEPTH_NBITS-1:0] app_mem_waddr;
    logic [WIDTH-1:0]       app_mem_wdata;
    logic                   app_mem_ack;
    logic [WIDTH-1:0]       app_mem_rdata;
    logic                   clr_start;
    logic                   clr_busy;
    logic                   clr_done;

    modport master (
        output clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        output app_mem_rd, app_mem_raddr, app_mem_wr, app_mem_waddr, app_mem_wdata,
        output clr_start,
        input  mem_ack, mem_rdata, app_mem_ack, app_mem_rdata, clr_busy, clr_done
    );

    modport slave (
        input  clk_div, reg_addr, reg_din, reg_rd, reg_wr, reg_ms,
        input  app_mem_rd, app_mem_raddr, app_mem_wr, app_mem_waddr, app_mem_wdata,
        input  clr_start,
        output mem_ack, mem_rdata, app_mem_ack, app_mem_rdata, clr_busy, clr_done
    );
endinterface

// File: rtl/pio_rw_wmem_nw.sv
// PIO-accessible wide memory (entries split into 32-bit PIO words) with app port and zero-fill engine.
// App read data 3 cycles after request; PIO write ack 2 cycles after last word, PIO word-0 read 2 cycles after RAM issue.
// App has absolute RAM priority: PIO reads/commits and clear writes stall behind it in save flags.
module pio_rw_wmem_nw #(
    parameter int   WIDTH       = 72,
    parameter int   DEPTH_NBITS = 10,
    parameter logic REG_WR_EN   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    pio_rw_wmem_nw_if.slave bus
);
    localparam int NWORDS     = (WIDTH + 31) / 32;
    localparam int WSEL_NBITS = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int NENTRY     = 1 << DEPTH_NBITS;
    localparam int PAD_W      = NWORDS * 32;

    localparam logic [WSEL_NBITS-1:0] LAST_WSEL = WSEL_NBITS'(NWORDS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [WIDTH-1:0]       mem [NENTRY];
    logic [WIDTH-1:0]       ram_rdata;

    logic                   app_rd_d1, app_rd_d2, app_wr_d1;
    logic [DEPTH_NBITS-1:0] app_raddr_d1, app_waddr_d1;
    logic [WIDTH-1:0]       app_wdata_d1;

    logic [WSEL_NBITS-1:0]  wsel;
    logic [DEPTH_NBITS-1:0] entry;
    logic                   pio_wr, pio_rd, pio_wr_evt, wr_ack_now, rd0_evt, rdk_evt;

    logic [PAD_W-1:0]       hold;
    logic [PAD_W-1:0]       wbuf_c;
    logic                   wr_sv;
    logic [DEPTH_NBITS-1:0] sv_waddr;
    logic [WIDTH-1:0]       sv_wdata;
    logic                   pio_wr_req, pio_commit;
    logic [DEPTH_NBITS-1:0] pio_waddr_c;
    logic [WIDTH-1:0]       pio_wdata_c;

    logic                   rd_sv;
    logic [DEPTH_NBITS-1:0] sv_raddr;
    logic                   pio_rd_req, pio_rd_issue, pio_rd_d1;
    logic [DEPTH_NBITS-1:0] pio_raddr_c;
    logic [PAD_W-1:0]       ram_pad;
    logic [PAD_W-1:0]       rbuf;
    logic [31:0]            rd_word_c;

    logic                   n_mem_ack, ack_evt;
    logic [1:0]             state;
    logic [DEPTH_NBITS-1:0] clr_cnt;
    logic                   clr_wr;

    // Entry/word decode of the PIO byte address; upper address bits are not decoded.
    assign wsel  = bus.reg_addr[WSEL_NBITS+1:2];
    assign entry = bus.reg_addr[DEPTH_NBITS+WSEL_NBITS+1:WSEL_NBITS+2];

    assign pio_wr     = bus.reg_ms & bus.reg_wr;
    assign pio_rd     = bus.reg_ms & bus.reg_rd;
    assign pio_wr_evt = pio_wr & (wsel == LAST_WSEL) & REG_WR_EN;
    // Non-last words, out-of-range words and disabled commits all ack straight away.
    assign wr_ack_now = pio_wr & ~pio_wr_evt;
    assign rd0_evt    = pio_rd & (wsel == '0);
    assign rdk_evt    = pio_rd & (wsel != '0);

    // A pending commit always uses the saved copy so later bus activity cannot corrupt it.
    assign pio_wr_req  = pio_wr_evt | wr_sv;
    assign pio_waddr_c = wr_sv ? sv_waddr : entry;
    assign pio_wdata_c = wr_sv ? sv_wdata : wbuf_c[WIDTH-1:0];
    assign clr_wr      = (state == ST_CLEAR) & ~app_wr_d1;
    assign pio_commit  = pio_wr_req & ~app_wr_d1 & (state == ST_IDLE);

    assign pio_rd_req   = rd0_evt | rd_sv;
    assign pio_raddr_c  = rd_sv ? sv_raddr : entry;
    assign pio_rd_issue = pio_rd_req & ~app_rd_d1;

    assign ack_evt = wr_ack_now | pio_commit | pio_rd_d1 | rdk_evt;

    assign bus.clr_busy = (state == ST_CLEAR);
    assign bus.clr_done = (state == ST_DONE);

    // Full entry to commit: held lower words plus the last word taken live from the bus.
    always_comb begin
        wbuf_c = hold;
        wbuf_c[(NWORDS-1)*32 +: 32] = bus.reg_din;
    end

    // Zero-extend the RAM word so the padding bits of the last PIO word read as 0.
    always_comb begin
        ram_pad = '0;
        ram_pad[WIDTH-1:0] = ram_rdata;
    end

    // Word select out of the read snapshot; words beyond NWORDS return 0.
    always_comb begin
        rd_word_c = '0;
        for (int k = 0; k < NWORDS; k++) begin
            if (wsel == WSEL_NBITS'(k)) rd_word_c = rbuf[k*32 +: 32];
        end
    end

    // Read-first 1R1W array: app wins the write port, then clear, then PIO commit.
    always_ff @(posedge clk) begin
        if (app_wr_d1)       mem[app_waddr_d1] <= app_wdata_d1;
        else if (clr_wr)     mem[clr_cnt]      <= '0;
        else if (pio_commit) mem[pio_waddr_c]  <= pio_wdata_c;

        if (app_rd_d1)         ram_rdata <= mem[app_raddr_d1];
        else if (pio_rd_issue) ram_rdata <= mem[pio_raddr_c];
    end

    // Unreset datapath registers: app stage-1 capture, holding/save buffers, read snapshot.
    always_ff @(posedge clk) begin
        app_raddr_d1 <= bus.app_mem_raddr;
        app_waddr_d1 <= bus.app_mem_waddr;
        app_wdata_d1 <= bus.app_mem_wdata;
        if (app_rd_d2) bus.app_mem_rdata <= ram_rdata;

        for (int k = 0; k < NWORDS; k++) begin
            if (pio_wr && wsel == WSEL_NBITS'(k)) hold[k*32 +: 32] <= bus.reg_din;
        end
        if (pio_wr_evt) begin
            sv_waddr <= entry;
            sv_wdata <= wbuf_c[WIDTH-1:0];
        end
        if (rd0_evt) sv_raddr <= entry;

        if (pio_rd_d1) begin
            rbuf          <= ram_pad;
            bus.mem_rdata <= ram_pad[31:0];
        end else if (rdk_evt) begin
            bus.mem_rdata <= rd_word_c;
        end
    end

    // Control pipeline, save flags and the clk_div-qualified PIO ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            app_rd_d1       <= 1'b0;
            app_rd_d2       <= 1'b0;
            app_wr_d1       <= 1'b0;
            bus.app_mem_ack <= 1'b0;
            wr_sv           <= 1'b0;
            rd_sv           <= 1'b0;
            pio_rd_d1       <= 1'b0;
            n_mem_ack       <= 1'b0;
            bus.mem_ack     <= 1'b0;
        end else begin
            app_rd_d1       <= bus.app_mem_rd;
            app_rd_d2       <= app_rd_d1;
            app_wr_d1       <= bus.app_mem_wr;
            bus.app_mem_ack <= app_rd_d2;
            wr_sv           <= pio_wr_req & ~pio_commit;
            rd_sv           <= pio_rd_req & ~pio_rd_issue;
            pio_rd_d1       <= pio_rd_issue;
            if (ack_evt)          n_mem_ack <= 1'b1;
            else if (bus.clk_div) n_mem_ack <= 1'b0;
            if (bus.clk_div)      bus.mem_ack <= n_mem_ack;
        end
    end

    // Clear engine: one zero write per unstalled cycle, stop after the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_start) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_wr) begin
                        clr_cnt <= clr_cnt + 1'b1;
                        if (clr_cnt == '1) state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Address bits above the entry field and padding of the commit buffer are intentionally unused.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.reg_addr, wbuf_c};
endmodule
